// File: rtl/detector_pkg.sv
// Shared types for the slow-edge detector: FSM state encoding
// and the counter saturation helper.
package detector_pkg;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      MIDIENDO = 2'd1,
      PARADO   = 2'd2
   } estado_t;

   // All-ones value for a counter of width w (w < 64).
   function automatic logic [63:0] sat_val(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/sincronizador.sv
// Parameterized flop chain bringing an asynchronous bit into clk_i.
// Ports: clk_i, rst_i (sync, active-high), d_i async in, q_o synced out.
module sincronizador #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] chain_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/detector_flancos_lento.sv
// Slow square-wave receiver: synchronizes sig_in, emits rise/fall ticks,
// measures period and high time in clk_in cycles and flags a stalled input.
// Ports: clk_in, reset (sync, active-high), sig_in (async);
//   rise_tick/fall_tick one-cycle ticks, periodo/alto last measurement,
//   periodo_valid update pulse, timeout level while the input is stalled.
// Optional macro DETECTOR_DEGLITCH_EN: require DEGLITCH_CYCLES stable
//   cycles before the internal level follows the synchronized input.
module detector_flancos_lento
   import detector_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_W           = 24,
   parameter int DEGLITCH_CYCLES = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic [CNT_W-1:0] periodo,
   output logic [CNT_W-1:0] alto,
   output logic             periodo_valid,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));
   localparam logic [CNT_W-1:0] UNO = CNT_W'(1);

   logic sync_s;
   logic lvl;

   sincronizador #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i(clk_in),
      .rst_i(reset),
      .d_i  (sig_in),
      .q_o  (sync_s)
   );

`ifdef DETECTOR_DEGLITCH_EN
   localparam int DG_W = $clog2(DEGLITCH_CYCLES + 1);

   logic [DG_W-1:0] dg_cnt_q, dg_cnt_d;
   logic            lvl_q, lvl_d;

   // Counter runs only while the synced input disagrees with lvl;
   // any agreement restarts the window, so short pulses vanish.
   always_comb begin
      lvl_d    = lvl_q;
      dg_cnt_d = '0;
      if (sync_s != lvl_q) begin
         if (dg_cnt_q == DG_W'(DEGLITCH_CYCLES - 1)) begin
            lvl_d = sync_s;
         end else begin
            dg_cnt_d = dg_cnt_q + DG_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         lvl_q    <= 1'b0;
         dg_cnt_q <= '0;
      end else begin
         lvl_q    <= lvl_d;
         dg_cnt_q <= dg_cnt_d;
      end
   end

   assign lvl = lvl_q;
`else
   logic unused_dg;
   assign unused_dg = ^DEGLITCH_CYCLES;
   assign lvl       = sync_s;
`endif

   logic prev_q;
   logic rise_q, fall_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= lvl;
         rise_q <= lvl & ~prev_q;
         fall_q <= ~lvl & prev_q;
      end
   end

   estado_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
   logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
   logic             h_run_q, h_run_d;
   logic [CNT_W-1:0] periodo_q, periodo_d;
   logic [CNT_W-1:0] alto_q, alto_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;

   // The FSM acts on the registered ticks so every measurement is
   // aligned to the tick cycles seen by downstream logic.
   always_comb begin
      state_d   = state_q;
      cnt_p_d   = cnt_p_q;
      cnt_h_d   = cnt_h_q;
      h_run_d   = h_run_q;
      periodo_d = periodo_q;
      alto_d    = alto_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      unique case (state_q)
         ESPERA: begin
            if (rise_q) begin
               state_d = MIDIENDO;
               cnt_p_d = UNO;
               cnt_h_d = UNO;
               h_run_d = 1'b1;
            end
         end
         MIDIENDO: begin
            if (rise_q) begin
               // A rise on the saturation cycle still publishes.
               periodo_d = cnt_p_q;
               alto_d    = cnt_h_q;
               valid_d   = 1'b1;
               cnt_p_d   = UNO;
               cnt_h_d   = UNO;
               h_run_d   = 1'b1;
            end else if (cnt_p_q == SAT) begin
               state_d   = PARADO;
               timeout_d = 1'b1;
            end else begin
               cnt_p_d = cnt_p_q + UNO;
               // cnt_h only advances alongside cnt_p: alto <= periodo.
               if (fall_q) begin
                  h_run_d = 1'b0;
               end else if (h_run_q) begin
                  cnt_h_d = cnt_h_q + UNO;
               end
            end
         end
         PARADO: begin
            if (rise_q) begin
               state_d   = MIDIENDO;
               timeout_d = 1'b0;
               cnt_p_d   = UNO;
               cnt_h_d   = UNO;
               h_run_d   = 1'b1;
            end
         end
         default: begin
            state_d = ESPERA;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q   <= ESPERA;
         cnt_p_q   <= '0;
         cnt_h_q   <= '0;
         h_run_q   <= 1'b0;
         periodo_q <= '0;
         alto_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_p_q   <= cnt_p_d;
         cnt_h_q   <= cnt_h_d;
         h_run_q   <= h_run_d;
         periodo_q <= periodo_d;
         alto_q    <= alto_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   assign rise_tick     = rise_q;
   assign fall_tick     = fall_q;
   assign periodo       = periodo_q;
   assign alto          = alto_q;
   assign periodo_valid = valid_q;
   assign timeout       = timeout_q;

endmodule

// File: tb/tb_detector_flancos_lento.sv
// Bench for detector_flancos_lento: vector table, corner sequences
// and randomized square waves against an event-level reference model.
module tb_detector_flancos_lento;

   localparam int CNT_W = 6;
   localparam int SAT   = 63;

   logic             clk_in = 1'b0;
   logic             reset;
   logic             sig_in;
   logic             rise_tick, fall_tick;
   logic [CNT_W-1:0] periodo, alto;
   logic             periodo_valid, timeout;

   detector_flancos_lento #(
      .SYNC_STAGES    (2),
      .CNT_W          (CNT_W),
      .DEGLITCH_CYCLES(4)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .sig_in       (sig_in),
      .rise_tick    (rise_tick),
      .fall_tick    (fall_tick),
      .periodo      (periodo),
      .alto         (alto),
      .periodo_valid(periodo_valid),
      .timeout      (timeout)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit model_on = 1'b1;

   int n_rise, n_fall, n_valid, n_to;
   int cap_p, cap_a;

   // Reference model: ticks follow the input two samples later;
   // measurements are differences of tick cycle numbers.
   bit [3:0] hist;
   bit       m_rise, m_fall, m_valid, m_to;
   int       m_per, m_alto;
   int       m_mode;  // 0 idle, 1 measuring, 2 stalled
   int       m_last, m_hi;
   bit       m_hi_open;

   task automatic model_edge(input bit r, input bit s);
      int c;
      cyc++;
      c = cyc - 1;
      if (r) begin
         hist = '0; m_rise = 0; m_fall = 0; m_valid = 0; m_to = 0;
         m_per = 0; m_alto = 0; m_mode = 0; m_hi_open = 0;
      end else begin
         m_valid = 0;
         if (m_rise) begin
            if (m_mode == 1) begin
               m_per = c - m_last;
               m_alto = m_hi;
               m_valid = 1;
            end
            m_to = 0;
            m_mode = 1;
            m_last = c;
            m_hi_open = 1;
            m_hi = 1;
         end else if (m_mode == 1) begin
            if (c - m_last == SAT) begin
               m_mode = 2;
               m_to = 1;
            end else if (m_hi_open) begin
               m_hi = c - m_last;
               if (m_fall) m_hi_open = 0;
            end
         end
         hist = {hist[2:0], s};
         m_rise = hist[2] & ~hist[3];
         m_fall = ~hist[2] & hist[3];
      end
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit s);
      logic [15:0] got, exp;
      reset  = r;
      sig_in = s;
      @(posedge clk_in);
      model_edge(r, s);
      #1;
      got = {rise_tick, fall_tick, periodo_valid, timeout, periodo, alto};
      if (rise_tick) n_rise++;
      if (fall_tick) n_fall++;
      if (timeout) n_to++;
      if (periodo_valid) begin
         n_valid++;
         cap_p = int'(periodo);
         cap_a = int'(alto);
      end
      if (model_on) begin
         exp = {m_rise, m_fall, m_valid, m_to,
                m_per[CNT_W-1:0], m_alto[CNT_W-1:0]};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d got=%h expected=%h", cyc, got, exp);
         end
      end
   endtask

   task automatic run_level(input bit s, input int n);
      for (int i = 0; i < n; i++) step(1'b0, s);
   endtask

   task automatic clr_counts();
      n_rise = 0; n_fall = 0; n_valid = 0; n_to = 0;
   endtask

   typedef struct {
      int hi;
      int lo;
      int nper;
      int exp_p;
      int exp_a;
      int exp_v;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int t_r, t_t, k;
      bit seen[5];
      tbl[0] = '{4, 6, 5, 10, 4, 4};
      tbl[1] = '{2, 4, 3, 6, 2, 3};
      tbl[2] = '{16, 16, 3, 32, 16, 3};
      tbl[3] = '{20, 5, 3, 25, 20, 3};

      reset = 1'b1;
      sig_in = 1'b0;
      clr_counts();
      cap_p = 0; cap_a = 0;
      repeat (3) step(1'b1, 1'b0);
      chk("reset_state",
          int'({rise_tick, fall_tick, periodo_valid, timeout, periodo, alto}), 0);

`ifndef DETECTOR_DEGLITCH_EN
      // Vector table of square waves.
      run_level(0, 6);
      for (int v = 0; v < 4; v++) begin
         clr_counts();
         for (int p = 0; p < tbl[v].nper; p++) begin
            run_level(1, tbl[v].hi);
            run_level(0, tbl[v].lo);
         end
         chk($sformatf("tbl%0d_valids", v), n_valid, tbl[v].exp_v);
         chk($sformatf("tbl%0d_rises", v), n_rise, tbl[v].nper);
         chk($sformatf("tbl%0d_falls", v), n_fall, tbl[v].nper);
         chk($sformatf("tbl%0d_periodo", v), cap_p, tbl[v].exp_p);
         chk($sformatf("tbl%0d_alto", v), cap_a, tbl[v].exp_a);
      end

      // Single edge: tick exactly two edges after the sampling edge.
      repeat (2) step(1'b1, 1'b0);
      run_level(0, 5);
      step(1'b0, 1'b1);
      k = cyc;
      seen[0] = rise_tick;
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 1'b1);
         seen[i] = rise_tick;
      end
      chk("edge_k1", int'(seen[1]), 0);
      chk("edge_k2", int'(seen[2]), 1);
      chk("edge_k3_width", int'(seen[3]), 0);
      chk("edge_k4", int'(seen[4]), 0);

      // Stall after a single rise, then recovery.
      repeat (2) step(1'b1, 1'b0);
      clr_counts();
      step(1'b0, 1'b1);
      t_r = -1;
      for (int i = 0; i < 10 && t_r < 0; i++) begin
         step(1'b0, 1'b0);
         if (rise_tick) t_r = cyc;
      end
      chk("stall_rise_seen", int'(t_r >= 0), 1);
      t_t = -1;
      for (int i = 0; i < 200 && t_t < 0; i++) begin
         step(1'b0, 1'b0);
         if (timeout) t_t = cyc;
      end
      chk("timeout_latency", t_t - t_r, SAT + 1);
      run_level(0, 10);
      chk("timeout_level", int'(timeout), 1);
      t_r = -1;
      for (int i = 0; i < 10 && t_r < 0; i++) begin
         step(1'b0, 1'b1);
         if (rise_tick) t_r = cyc;
      end
      step(1'b0, 1'b1);
      chk("timeout_clear", int'(timeout), 0);
      chk("wake_no_valid", n_valid, 0);
      run_level(1, 2);
      run_level(0, 6);
      for (int p = 0; p < 3; p++) begin
         run_level(1, 4);
         run_level(0, 6);
      end
      chk("after_stall_periodo", cap_p, 10);
      chk("after_stall_alto", cap_a, 4);

      // Rise on the saturation cycle wins over timeout.
      repeat (2) step(1'b1, 1'b0);
      run_level(0, 4);
      clr_counts();
      run_level(1, 10);
      run_level(0, SAT - 10);
      run_level(1, 5);
      run_level(0, 5);
      chk("sat_rise_periodo", cap_p, SAT);
      chk("sat_rise_alto", cap_a, 10);
      chk("sat_rise_no_timeout", n_to, 0);

      // Reset in the middle of a high phase.
      run_level(1, 4);
      run_level(0, 6);
      run_level(1, 2);
      step(1'b1, 1'b1);
      chk("midreset_out",
          int'({rise_tick, fall_tick, periodo_valid, timeout, periodo, alto}), 0);
      run_level(1, 2);
      run_level(0, 6);
      for (int p = 0; p < 2; p++) begin
         run_level(1, 4);
         run_level(0, 6);
      end
      chk("midreset_periodo", cap_p, 10);
      chk("midreset_alto", cap_a, 4);

      // Random square waves with occasional stalls and resets.
      for (int it = 0; it < 60; it++) begin
         int hi, lo;
         hi = $urandom_range(1, 30);
         lo = $urandom_range(1, 30);
         if ($urandom_range(0, 7) == 0) lo = 70;
         run_level(1, hi);
         if ($urandom_range(0, 15) == 0) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
         end
         run_level(0, lo);
      end
`else
      model_on = 1'b0;
      run_level(0, 10);
      clr_counts();
      run_level(1, 2);
      run_level(0, 20);
      chk("glitch_rises", n_rise, 0);
      chk("glitch_falls", n_fall, 0);
      chk("glitch_periodo", int'(periodo), 0);
      run_level(1, 4);
      run_level(0, 20);
      chk("pulse_rises", n_rise, 1);
      chk("pulse_falls", n_fall, 1);
      chk("pulse_periodo", int'(periodo), 0);
      chk("pulse_valid", n_valid, 0);
      k = 0; t_r = 0; t_t = 0;
      seen[0] = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
